dmem_hs: RTL

Parametrised handshaked data memory for the CPU load/store path. It replaces the combinational-read data RAM with a synchronous-read array behind a valid/ready request channel and a valid/ready response channel. It supports configurable depth, a read latency of 1 or 2 cycles, byte/half/word access with sign or zero extension, and error reporting for misaligned, out-of-range and illegal-size accesses. It sits between the load/store unit and the RAM array; one request is outstanding at a time.

---
 rtl/dmem_hs.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_hs.sv
// -----------------------------------------------------------------------------
// dmem_hs : handshaked data memory for the CPU load/store path.
//
// Synchronous-read RAM behind a valid/ready request channel and a valid/ready
// response channel. One request is outstanding at a time. Supports byte/half/
// word accesses with sign or zero extension on loads. Misaligned, out-of-range
// and illegal-size accesses are reported through resp_err_o.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   READ_LAT    : accept-to-response latency for loads (1 or 2)
//   IDX_W       : word-index width (derived)
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   req_valid_i    : request present
//   req_ready_o    : block can accept a request (high only in IDLE)
//   req_addr_i     : byte address
//   req_wdata_i    : store data, low byte/half/word used according to size
//   req_write_i    : 1 = store, 0 = load
//   req_size_i     : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i : load zero-extends when 1, sign-extends when 0
//   resp_valid_o   : response present
//   resp_ready_i   : consumer accepts the response
//   resp_rdata_o   : extended load data; 0 for stores and errors
//   resp_err_o     : request faulted
// -----------------------------------------------------------------------------
module dmem_hs #(
    parameter int  DEPTH_WORDS = 256,
    parameter int  READ_LAT    = 1,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_e;

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_e           state_q, state_d;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      raw_q;

    // Request attributes captured on the accept edge; they drive the
    // response decode so later req_* changes cannot disturb it.
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             err_q;
    logic             load_ok_q;

    logic             accept;
    logic             in_range;
    logic             req_err;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [31:0]      load_data;

    assign accept   = req_valid_i && (state_q == S_IDLE);
    assign idx      = req_addr_i[IDX_W+1:2];
    assign in_range = {2'b00, req_addr_i[31:2]} < DEPTH_L;

    // Error check and byte-lane decode. Store data is replicated across the
    // lanes so each enabled lane simply takes its own byte slice.
    always_comb begin : req_decode
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        req_err = !in_range;
        be      = 4'b0000;
        wlanes  = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be     = 4'b0001 << req_addr_i[1:0];
                wlanes = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_err = req_err || req_addr_i[0];
                be      = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                req_err = req_err || (req_addr_i[1:0] != 2'b00);
                be      = 4'b1111;
            end
            default: req_err = 1'b1;
        endcase
    end

    // RAM array and its synchronous read register.
    // NOTE: the array is deliberately left out of reset; resetting a RAM
    // would turn it into a huge flop bank and reset must not erase stores.
    always_ff @(posedge clk) begin : ram
        if (accept && !req_err) begin
            if (req_write_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
                    end
                end
            end else begin
                raw_q <= mem_q[idx];
            end
        end
    end

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : attr_reg
        if (rst) begin
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else if (accept) begin
            lane_q    <= req_addr_i[1:0];
            size_q    <= req_size_i;
            uns_q     <= req_unsigned_i;
            err_q     <= req_err;
            load_ok_q <= !req_err && !req_write_i;
        end
    end

    // Next-state logic. Only good loads with a 2-cycle latency detour
    // through RD_WAIT; stores and faults answer one cycle after accept.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_err && !req_write_i && (READ_LAT == 2)) begin
                        state_d = S_RD_WAIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RD_WAIT: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane select and extension of the raw word. Inputs are all flops, so
    // the response is stable for as long as the block sits in RESP.
    always_comb begin : load_extend
        load_data = raw_q;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    load_data = {24'h0, raw_q[7:0]};
                    2'd1:    load_data = {24'h0, raw_q[15:8]};
                    2'd2:    load_data = {24'h0, raw_q[23:16]};
                    default: load_data = {24'h0, raw_q[31:24]};
                endcase
                if (!uns_q && load_data[7]) begin
                    load_data[31:8] = 24'hFF_FFFF;
                end
            end
            2'b01: begin
                load_data = lane_q[1] ? {16'h0, raw_q[31:16]} : {16'h0, raw_q[15:0]};
                if (!uns_q && load_data[15]) begin
                    load_data[31:16] = 16'hFFFF;
                end
            end
            default: load_data = raw_q;
        endcase
    end

    // Output decode from state and captured attributes.
    always_comb begin : outputs
        req_ready_o  = (state_q == S_IDLE);
        resp_valid_o = (state_q == S_RESP);
        resp_err_o   = (state_q == S_RESP) && err_q;
        resp_rdata_o = ((state_q == S_RESP) && load_ok_q) ? load_data : 32'h0;
    end

endmodule
